phase_timer: RTL and testbench
==============================

PHASE_TIMER -- requirements
Module: phase_timer

Interface
REQ-001 Parameter TICK_DIV, default 100000000, means clk cycles per countdown second (minimum 2).
REQ-002 Parameter RED_DEF, default 9, is the reset duration of the RED phase in seconds.
REQ-003 Parameter GREEN_DEF, default 7, is the reset duration of the GREEN phase in seconds.
REQ-004 Parameter YELLOW_DEF, default 3, is the reset duration of the YELLOW phase in seconds.
REQ-005 Port clk  in  1  SHALL be the single clock; all state updates occur on its rising edge.
REQ-006 Port reset_n  in  1  SHALL be the reset: asynchronous, active-low.
REQ-007 Port state  in  2  SHALL carry the current light phase: 00 IDLE, 01 RED, 10 GREEN, 11 YELLOW.
REQ-008 Port cfg_valid  in  1  SHALL request a duration write.
REQ-009 Port cfg_sel  in  2  SHALL select the target phase, using the state encoding.
REQ-010 Port cfg_value  in  4  SHALL carry the new duration in seconds.
REQ-011 Port cfg_ready  out  1  SHALL indicate that a duration write can be accepted.
REQ-012 Port timer_value  out  4  SHALL carry the remaining seconds of the current phase (registered).
REQ-013 Port timer_done  out  1  SHALL carry a one-cycle pulse when the phase time expires (registered).
REQ-014 Port sec_tick  out  1  SHALL carry a one-cycle pulse at every counted second (registered).

Function
REQ-015 Three 4-bit duration registers (dur_red, dur_green, dur_yellow) SHALL hold the phase lengths.
REQ-016 cfg_ready SHALL be combinational and equal 1 only while state==IDLE.
REQ-017 A write SHALL be accepted on the edge where cfg_valid && cfg_ready; cfg_sel 01/10/11 SHALL update the matching register, and cfg_sel 00 SHALL be accepted with no effect.
REQ-018 cfg_value 0 SHALL be stored as 1; no duration may be zero.
REQ-019 Writes offered while cfg_ready=0 SHALL be ignored, with no state change.
REQ-020 A register prev_state SHALL track state every cycle; a phase change is defined as state != prev_state.
REQ-021 On a phase change into RED/GREEN/YELLOW, the block SHALL load timer_value with the matching duration, clear the prescaler and clear timer_done, on the same edge.
REQ-022 On a phase change into IDLE, or at any time while state==IDLE, the block SHALL set timer_value=0, hold the prescaler at 0 and keep timer_done and sec_tick at 0.
REQ-023 Prescaler: in a non-IDLE phase with no phase change, the prescaler SHALL count 0..TICK_DIV-1 and wrap to 0; sec_tick SHALL be registered 1 in the cycle after the count equals TICK_DIV-1.
REQ-024 On a wrap with timer_value>1, timer_value SHALL decrement by 1.
REQ-025 On a wrap with timer_value==1, timer_value SHALL become 0 and timer_done SHALL be 1 for exactly one following cycle.
REQ-026 On a wrap with timer_value==0 (expired, phase not yet changed), the value SHALL hold at 0 and timer_done SHALL NOT re-assert; at most one done pulse is allowed per phase entry.
REQ-027 A phase change SHALL take priority over a simultaneous wrap: the reload wins, and no decrement or done occurs on that edge.
REQ-028 A phase change mid-count (state forced to a new phase) SHALL reload immediately; the remaining time is discarded.
REQ-029 A new duration SHALL take effect only at the next phase load; a phase already running is unaffected.
REQ-030 An out-of-range loaded value is not possible; timer_value SHALL stay within 0..15.

Reset
REQ-031 While reset_n=0: dur_red=RED_DEF, dur_green=GREEN_DEF, dur_yellow=YELLOW_DEF, prev_state=00, prescaler=0, timer_value=0, timer_done=0, sec_tick=0.
REQ-032 Reset assertion mid-phase SHALL apply the REQ-031 values immediately (asynchronously), discarding any written durations.
REQ-033 After release, a non-IDLE state SHALL be treated as a phase change and loaded on the first edge.

Verification (TICK_DIV=4)
REQ-034 Reset release, state 00->01: timer_value=9 the edge after the change, then 8,7,...,1 every 4 cycles; after 1 comes 0 with timer_done high for exactly 1 cycle.
REQ-035 In IDLE, write cfg_sel=10, cfg_value=5; cfg_ready=1 and the write is accepted. Then state->10: timer_value loads 5.
REQ-036 In RED, drive cfg_valid with cfg_sel=01, cfg_value=2: cfg_ready=0, dur_red is unchanged, and the next RED entry loads 9.
REQ-037 In IDLE, write cfg_value=0 to YELLOW; the next YELLOW entry loads 1, and timer_done pulses 4-5 cycles after entry.
REQ-038 Force state 01->10 on the same edge as a prescaler wrap with timer_value=1: timer_value=GREEN duration, and no timer_done pulse.
REQ-039 Pull reset_n low mid-GREEN with timer_value=4: all outputs go to 0 without waiting for a clock edge, and the durations return to their defaults.

Source files
------------

// File: rtl/phase_timer.sv
// Per-phase countdown timer for a traffic-light sequencer. It reloads on each phase entry,
// counts down once per prescaled second, and pulses done once when the phase expires.
module phase_timer #(
  parameter int unsigned TICK_DIV   = 100000000,
  parameter int unsigned RED_DEF    = 9,
  parameter int unsigned GREEN_DEF  = 7,
  parameter int unsigned YELLOW_DEF = 3
) (
  input  logic       clk,
  input  logic       reset_n,
  input  logic [1:0] state,
  input  logic       cfg_valid,
  input  logic [1:0] cfg_sel,
  input  logic [3:0] cfg_value,
  output logic       cfg_ready,
  output logic [3:0] timer_value,
  output logic       timer_done,
  output logic       sec_tick
);

  localparam int unsigned PW = (TICK_DIV > 2) ? $clog2(TICK_DIV) : 1;
  localparam logic [PW-1:0] PrescMax = PW'(TICK_DIV - 1);

  typedef enum logic [1:0] {
    PhIdle   = 2'b00,
    PhRed    = 2'b01,
    PhGreen  = 2'b10,
    PhYellow = 2'b11
  } phase_e;

  logic [3:0]    r_dur_red, r_dur_green, r_dur_yellow;
  logic [1:0]    r_prev_state;
  logic [PW-1:0] r_presc;
  logic [3:0]    r_timer;
  logic          r_done, r_tick;

  logic [3:0]    w_dur_red, w_dur_green, w_dur_yellow;
  logic [PW-1:0] w_presc;
  logic [3:0]    w_timer;
  logic          w_done, w_tick;
  logic          w_change, w_wrap;
  logic [3:0]    w_wr_val, w_load_val;

  always_comb begin
    cfg_ready  = (phase_e'(state) == PhIdle);
    w_change   = (state != r_prev_state);
    w_wrap     = (r_presc == PrescMax);
    // A zero duration would never expire, so it is promoted to one second.
    w_wr_val   = (cfg_value == 4'd0) ? 4'd1 : cfg_value;

    w_dur_red    = r_dur_red;
    w_dur_green  = r_dur_green;
    w_dur_yellow = r_dur_yellow;
    if (cfg_valid && cfg_ready) begin
      case (phase_e'(cfg_sel))
        PhRed:    w_dur_red    = w_wr_val;
        PhGreen:  w_dur_green  = w_wr_val;
        PhYellow: w_dur_yellow = w_wr_val;
        default:  ;
      endcase
    end

    case (phase_e'(state))
      PhRed:    w_load_val = r_dur_red;
      PhGreen:  w_load_val = r_dur_green;
      PhYellow: w_load_val = r_dur_yellow;
      default:  w_load_val = 4'd0;
    endcase

    w_presc = r_presc;
    w_timer = r_timer;
    w_done  = 1'b0;
    w_tick  = 1'b0;
    if (phase_e'(state) == PhIdle) begin
      w_presc = '0;
      w_timer = 4'd0;
    end else if (w_change) begin
      // Reload wins over a coincident wrap; leftover time is discarded.
      w_presc = '0;
      w_timer = w_load_val;
    end else if (w_wrap) begin
      w_presc = '0;
      w_tick  = 1'b1;
      if (r_timer > 4'd1) begin
        w_timer = r_timer - 4'd1;
      end else if (r_timer == 4'd1) begin
        w_timer = 4'd0;
        w_done  = 1'b1;
      end
    end else begin
      w_presc = r_presc + PW'(1);
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_dur_red    <= 4'(RED_DEF);
      r_dur_green  <= 4'(GREEN_DEF);
      r_dur_yellow <= 4'(YELLOW_DEF);
      r_prev_state <= 2'b00;
      r_presc      <= '0;
      r_timer      <= 4'd0;
      r_done       <= 1'b0;
      r_tick       <= 1'b0;
    end else begin
      r_dur_red    <= w_dur_red;
      r_dur_green  <= w_dur_green;
      r_dur_yellow <= w_dur_yellow;
      r_prev_state <= state;
      r_presc      <= w_presc;
      r_timer      <= w_timer;
      r_done       <= w_done;
      r_tick       <= w_tick;
    end
  end

  assign timer_value = r_timer;
  assign timer_done  = r_done;
  assign sec_tick    = r_tick;

endmodule

// File: tb/tb_phase_timer.sv
// Scoreboard bench for phase_timer: a cycle-count reference model predicts outputs per edge,
// a negedge monitor pops and compares them against the DUT.
module tb_phase_timer;

  localparam int unsigned TD = 4;
  localparam int RED_D = 9, GREEN_D = 7, YELLOW_D = 3;

  logic       clk = 1'b0;
  logic       reset_n = 1'b0;
  logic [1:0] state = 2'b00;
  logic       cfg_valid = 1'b0;
  logic [1:0] cfg_sel = 2'b00;
  logic [3:0] cfg_value = 4'd0;
  logic       cfg_ready;
  logic [3:0] timer_value;
  logic       timer_done;
  logic       sec_tick;

  phase_timer #(
    .TICK_DIV  (TD),
    .RED_DEF   (RED_D),
    .GREEN_DEF (GREEN_D),
    .YELLOW_DEF(YELLOW_D)
  ) dut (
    .clk        (clk),
    .reset_n    (reset_n),
    .state      (state),
    .cfg_valid  (cfg_valid),
    .cfg_sel    (cfg_sel),
    .cfg_value  (cfg_value),
    .cfg_ready  (cfg_ready),
    .timer_value(timer_value),
    .timer_done (timer_done),
    .sec_tick   (sec_tick)
  );

  always #5 clk = ~clk;

  typedef struct {
    int timer;
    int done;
    int tick;
  } exp_t;

  exp_t exp_q[$];
  int checks = 0;
  int errors = 0;

  // Reference model: time since phase entry, in cycles, determines every output.
  int m_dur[4];
  int m_prev = 0;
  int m_k = 0;
  int m_ld = 0;

  always @(posedge clk) begin
    exp_t e;
    int st;
    st = int'(state);
    if (!reset_n) begin
      m_dur[1] = RED_D;
      m_dur[2] = GREEN_D;
      m_dur[3] = YELLOW_D;
      m_prev = 0;
      m_k = 0;
      m_ld = 0;
    end else begin
      if (st == 0) begin
        if (cfg_valid && cfg_sel != 2'b00)
          m_dur[int'(cfg_sel)] = (cfg_value == 4'd0) ? 1 : int'(cfg_value);
      end else if (st != m_prev) begin
        m_ld = m_dur[st];
        m_k = 0;
      end else begin
        m_k++;
      end
      m_prev = st;
    end
    if (!reset_n || st == 0) begin
      e.timer = 0;
      e.done = 0;
      e.tick = 0;
    end else begin
      e.timer = (m_k / int'(TD) >= m_ld) ? 0 : m_ld - m_k / int'(TD);
      e.tick = (m_k > 0 && m_k % int'(TD) == 0) ? 1 : 0;
      e.done = (m_k == int'(TD) * m_ld) ? 1 : 0;
    end
    exp_q.push_back(e);
  end

  always @(negedge clk) begin
    exp_t e;
    checks++;
    if (cfg_ready !== (state == 2'b00)) begin
      errors++;
      $display("FAIL cfg_ready: got %b, want %b (state=%b)", cfg_ready, state == 2'b00, state);
    end
    if (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      checks += 3;
      if (timer_value !== 4'(e.timer)) begin
        errors++;
        $display("FAIL timer_value @%0t: got %0d, want %0d", $time, timer_value, e.timer);
      end
      if (timer_done !== 1'(e.done)) begin
        errors++;
        $display("FAIL timer_done @%0t: got %b, want %0d", $time, timer_done, e.done);
      end
      if (sec_tick !== 1'(e.tick)) begin
        errors++;
        $display("FAIL sec_tick @%0t: got %b, want %0d", $time, sec_tick, e.tick);
      end
    end
  end

  task automatic step(input logic [1:0] s, input int n, input logic v,
                      input logic [1:0] sel, input logic [3:0] val);
    state = s;
    cfg_valid = v;
    cfg_sel = sel;
    cfg_value = val;
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  // Asynchronous reset pulse: outputs must clear before any clock edge.
  task automatic pulse_reset(input logic [1:0] s_after);
    @(negedge clk);
    #1;
    reset_n = 1'b0;
    #1;
    checks++;
    if (timer_value !== 4'd0 || timer_done !== 1'b0 || sec_tick !== 1'b0) begin
      errors++;
      $display("FAIL async_reset: got timer=%0d done=%b tick=%b, want 0 0 0",
               timer_value, timer_done, sec_tick);
    end
    repeat (2) @(posedge clk);
    #1;
    state = s_after;
    reset_n = 1'b1;
  endtask

  initial begin
    repeat (3) @(posedge clk);
    #1;
    // Reset release straight into RED: 9 down to 0, one done pulse, then hold at 0.
    state = 2'b01;
    reset_n = 1'b1;
    step(2'b01, 45, 1'b0, 2'b00, 4'd0);
    // GREEN duration write in IDLE, then GREEN loads 5.
    step(2'b00, 3, 1'b1, 2'b10, 4'd5);
    step(2'b10, 24, 1'b0, 2'b00, 4'd0);
    // Write attempt during RED is ignored; the next RED entry still loads 9.
    step(2'b01, 6, 1'b1, 2'b01, 4'd2);
    step(2'b00, 2, 1'b0, 2'b00, 4'd0);
    step(2'b01, 8, 1'b0, 2'b00, 4'd0);
    // Zero duration written to YELLOW is stored as 1.
    step(2'b00, 2, 1'b1, 2'b11, 4'd0);
    step(2'b11, 10, 1'b0, 2'b00, 4'd0);
    // RED->GREEN on the edge RED would have expired: reload, no done.
    step(2'b00, 2, 1'b0, 2'b00, 4'd0);
    step(2'b01, 36, 1'b0, 2'b00, 4'd0);
    step(2'b10, 3, 1'b0, 2'b00, 4'd0);
    // GREEN (5) at timer 4, then reset; defaults must return.
    step(2'b00, 2, 1'b0, 2'b00, 4'd0);
    step(2'b10, 6, 1'b0, 2'b00, 4'd0);
    pulse_reset(2'b00);
    step(2'b10, 12, 1'b0, 2'b00, 4'd0);
    step(2'b11, 16, 1'b0, 2'b00, 4'd0);

    for (int i = 0; i < 60; i++) begin
      if ($urandom_range(0, 9) == 0) begin
        pulse_reset(2'($urandom_range(0, 3)));
      end
      step(2'($urandom_range(0, 3)), int'($urandom_range(1, 70)),
           1'($urandom_range(0, 1)), 2'($urandom_range(0, 3)), 4'($urandom_range(0, 15)));
    end

    step(2'b00, 2, 1'b0, 2'b00, 4'd0);
    @(negedge clk);
    #1;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
